// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the memory-stage load/store unit: access types,
// FSM states and the writeback bubble value.
package riscv_mem_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam logic [4:0] WB_BUBBLE = 5'b0;

endpackage

// File: rtl/lsu_align.sv
// Combinational store formatting, load lane extraction/extension and the
// misaligned/illegal access check.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  st_type_i,
  input  logic [1:0]  st_off_i,
  input  logic        is_store_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        fault_o,
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);

  logic [31:0] lane;

  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    fault_o = 1'b0;
    case (st_type_i)
      LSU_B: begin
        wdata_o = {4{sdata_i[7:0]}};
        wstrb_o = 4'b0001 << st_off_i;
      end
      LSU_H: begin
        wdata_o = {2{sdata_i[15:0]}};
        wstrb_o = 4'b0011 << st_off_i;
        fault_o = st_off_i[0];
      end
      LSU_W: begin
        wdata_o = sdata_i;
        wstrb_o = '1;
        fault_o = |st_off_i;
      end
      // Unsigned variants only exist for loads.
      LSU_BU:  fault_o = is_store_i;
      LSU_HU:  fault_o = is_store_i | st_off_i[0];
      default: fault_o = 1'b1;
    endcase
    if (!is_store_i) begin
      wdata_o = '0;
      wstrb_o = '0;
    end
  end

  always_comb begin
    lane = rdata_i >> {ld_off_i, 3'b000};
    case (ld_type_i)
      LSU_B:   ldata_o = {{24{lane[7]}}, lane[7:0]};
      LSU_H:   ldata_o = {{16{lane[15]}}, lane[15:0]};
      LSU_W:   ldata_o = rdata_i;
      LSU_BU:  ldata_o = {24'b0, lane[7:0]};
      LSU_HU:  ldata_o = {16'b0, lane[15:0]};
      default: ldata_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one req/ack transaction per load or store,
// pipeline stall while it is outstanding, zero-latency pass-through otherwise.
module mem_access_unit
  import riscv_mem_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  LoadOrStoreType_i,
  input  logic [4:0]  WB_control_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] StoreData_i,
  input  logic [4:0]  RegDst_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [4:0]  WB_control,
  output logic [31:0] ALUResult,
  output logic [31:0] LoadData,
  output logic [4:0]  RegDst,
  output logic        misaligned
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [4:0]  wb_q, wb_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] ldata_q, ldata_d;

  logic        mem_op;
  logic        fault;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_wstrb;
  logic [31:0] ld_ext;

  assign mem_op = MemRead_i | MemWrite_i;

  lsu_align u_align (
    .st_type_i  (LoadOrStoreType_i),
    .st_off_i   (ALUResult_i[1:0]),
    .is_store_i (MemWrite_i),
    .sdata_i    (StoreData_i),
    .wdata_o    (fmt_wdata),
    .wstrb_o    (fmt_wstrb),
    .fault_o    (fault),
    .ld_type_i  (type_q),
    .ld_off_i   (addr_q[1:0]),
    .rdata_i    (dmem_rdata),
    .ldata_o    (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wb_d    = wb_q;
    rd_d    = rd_q;
    ldata_d = ldata_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !fault) begin
          type_d  = LoadOrStoreType_i;
          addr_d  = ALUResult_i;
          we_d    = MemWrite_i;
          wdata_d = fmt_wdata;
          wstrb_d = fmt_wstrb;
          wb_d    = WB_control_i;
          rd_d    = RegDst_i;
          ldata_d = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (dmem_ack) begin
          ldata_d = we_q ? '0 : ld_ext;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      type_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wb_q    <= '0;
      rd_q    <= '0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      ldata_q <= ldata_d;
    end
  end

  // Outputs are forced to zero while reset is held, even the pass-through path.
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_wstrb = '0;
    mem_stall  = 1'b0;
    WB_control = WB_BUBBLE;
    ALUResult  = '0;
    LoadData   = '0;
    RegDst     = '0;
    misaligned = 1'b0;
    if (RESET) begin
      case (state_q)
        ST_IDLE: begin
          ALUResult = ALUResult_i;
          RegDst    = RegDst_i;
          if (mem_op) begin
            misaligned = fault;
            mem_stall  = !fault;
          end else begin
            WB_control = WB_control_i;
          end
        end
        ST_BUSY: begin
          dmem_req   = 1'b1;
          dmem_we    = we_q;
          dmem_addr  = {addr_q[31:2], 2'b00};
          dmem_wdata = wdata_q;
          dmem_wstrb = wstrb_q;
          mem_stall  = 1'b1;
          ALUResult  = addr_q;
          RegDst     = rd_q;
        end
        ST_DONE: begin
          WB_control = wb_q;
          ALUResult  = addr_q;
          RegDst     = rd_q;
          LoadData   = ldata_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. It issues one data-memory request per load or store over a req/ack bus and stalls the pipeline until the access completes. It formats store data and byte strobes and extracts and extends load data. Non-memory instructions pass through combinationally with zero added latency.

## Interface
- No parameters; data and address width fixed at 32 bits.
- CLK  in  1  pipeline clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MemRead_i / MemWrite_i  in  1 each  load / store request from EX/MEM; both high is treated as store.
- LoadOrStoreType_i  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 illegal.
- WB_control_i  in  5  writeback control from EX/MEM.
- ALUResult_i  in  32  effective address, or ALU result for non-memory ops.
- StoreData_i  in  32  store operand.
- RegDst_i  in  5  destination register.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_wstrb  out  4  byte enables; 0000 on reads.
- dmem_ack  in  1  one-cycle completion; read data valid in the same cycle.
- dmem_rdata  in  32  read word.
- mem_stall  out  1  freezes IF/ID/EX and holds the EX/MEM inputs.
- WB_control  out  5  to MEM/WB; 0 = bubble.
- ALUResult / LoadData  out  32 each  to MEM/WB.
- RegDst  out  5  to MEM/WB.
- misaligned  out  1  one-cycle fault flag for misaligned or illegal accesses.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, no memory op: outputs pass through combinationally, LoadData=0, mem_stall=0.
- IDLE, memory op, aligned and legal: capture type, address, lane, WB_control, RegDst, and formatted wdata/wstrb. Assert mem_stall; output WB_control=0. Go to BUSY.
- IDLE, memory op, misaligned or illegal: no request issued. misaligned=1 for that cycle; WB_control=0; mem_stall=0; remain in IDLE.
  - H/HU is misaligned when addr[0]=1; W when addr[1:0]≠0.
  - Stores use the B/H/W rules; store with type BU/HU is illegal.
- BUSY: dmem_req=1 with stable dmem_we/addr/wdata/wstrb; mem_stall=1; WB_control=0.
  - On dmem_ack: register the formatted load result (0 for stores) and go to DONE.
- DONE: dmem_req=0; mem_stall=0. Output captured WB_control/RegDst/ALUResult and registered LoadData. EX/MEM inputs are ignored because they still hold the same instruction. Go to IDLE next cycle.
- Store formatting:
  - B: wdata={4{sd[7:0]}}, wstrb=0001<<a[1:0].
  - H: wdata={2{sd[15:0]}}, wstrb=0011<<a[1:0].
  - W: wdata=sd, wstrb=1111.
- Load extraction: lane = rdata>>(8*a[1:0]). B/H sign-extend; BU/HU zero-extend; W takes the full word.
- dmem_ack outside BUSY is ignored.

## Timing
- Reset (RESET low, any state, including mid-request): state becomes IDLE, captured registers clear, dmem_req drops immediately. While RESET is low, all outputs are 0, including mem_stall and pass-through outputs.
- Load or store with ack on the first BUSY cycle: detect cycle N (IDLE), request cycle N+1, result visible in cycle N+2 (DONE). mem_stall is high in N and N+1, i.e. 2 stall cycles plus 1 per extra wait cycle.
- dmem_req rises at the edge ending N and falls at the edge ending the ack cycle.
- Back-to-back memory ops: the next op is detected in the cycle after DONE; there is no overlap.
- Non-memory ops and misaligned faults add 0 cycles.

## Structure
- Shared package/header riscv_mem_pkg holds:
  - access-type encodings LSU_B/LSU_H/LSU_W/LSU_BU/LSU_HU;
  - FSM state encoding;
  - WB_control bubble constant 5'b0.
- One combinational sub-module, lsu_align, computes wstrb, wdata, load extraction/extension and the misalign/illegal check. The FSM and registers stay in mem_access_unit.

## Test plan
- LB at 0x1003, rdata=0x80FF_1234, ack on first BUSY cycle -> LoadData=0xFFFF_FF80 in DONE, 2 stall cycles, dmem_addr=0x1000.
- SH at 0x2002, StoreData=0x0000_BEEF -> dmem_we=1, wdata=0xBEEF_BEEF, wstrb=1100; WB_control passes in DONE.
- LW at 0x3000 with ack delayed 3 cycles -> dmem_req held 4 cycles with stable address, mem_stall high for 5 cycles, LoadData=rdata.
- LHU at 0x4001 -> misaligned=1 for one cycle, no dmem_req, WB_control=0, mem_stall=0.
- RESET low in BUSY, then an ack arriving after reset -> outputs all 0; the stale ack is ignored; the next LBU at 0x10 with rdata=0x0000_9A00 yields LoadData=0x0000_0000 (lane 0 = 0x00).
- Non-memory op, ALUResult_i=0x55 -> same-cycle ALUResult=0x55, LoadData=0, mem_stall=0.
